// File: rtl/z_cska_pipe.sv
// z_cska_pipe: pipelined carry-skip adder/subtractor. Each stage resolves one BLOCK-bit skip group.
// Handshake: in_ready = !out_valid | out_ready. When it is low, the whole pipeline holds.
`default_nettype none

module z_cska_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NB = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("z_cska_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  // Stage registers. The a/b words shift right by BLOCK per stage, so the next
  // group to resolve always sits in the low bits. The sum word shifts in from
  // the top, so after NB stages slice 0 ends up at bit 0.
  logic [WIDTH-1:0] a_q [NB];
  logic [WIDTH-1:0] b_q [NB];
  logic [WIDTH-1:0] s_q [NB];
  logic             c_q [NB];
  logic             v_q [NB];
  logic             ovf_q;

  logic [WIDTH-1:0] a_in [NB];
  logic [WIDTH-1:0] b_in [NB];
  logic [WIDTH-1:0] s_in [NB];
  logic             cy_in [NB];
  logic             v_in [NB];

  logic [WIDTH-1:0] a_nx [NB];
  logic [WIDTH-1:0] b_nx [NB];
  logic [WIDTH-1:0] s_nx [NB];
  logic             c_nx [NB];
  logic             ovf_nx;

  logic adv;

  assign adv       = !v_q[NB-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[NB-1];
  assign sum       = s_q[NB-1];
  assign c_out     = c_q[NB-1];
  assign overflow  = ovf_q;

  always_comb begin
    a_in[0]  = a;
    b_in[0]  = sub ? ~b : b;
    s_in[0]  = '0;
    cy_in[0] = sub ? 1'b1 : c_in;
    v_in[0]  = in_valid && adv;
    for (int k = 1; k < NB; k++) begin
      a_in[k]  = a_q[k-1];
      b_in[k]  = b_q[k-1];
      s_in[k]  = s_q[k-1];
      cy_in[k] = c_q[k-1];
      v_in[k]  = v_q[k-1];
    end
  end

  logic [BLOCK-1:0] p, g, sl;
  logic             c, c_top;

  always_comb begin
    p      = '0;
    g      = '0;
    sl     = '0;
    c      = 1'b0;
    c_top  = 1'b0;
    ovf_nx = 1'b0;
    for (int k = 0; k < NB; k++) begin
      p = a_in[k][BLOCK-1:0] ^ b_in[k][BLOCK-1:0];
      g = a_in[k][BLOCK-1:0] & b_in[k][BLOCK-1:0];
      c = cy_in[k];
      for (int i = 0; i < BLOCK; i++) begin
        sl[i] = p[i] ^ c;
        c_top = c;
        c     = g[i] | (p[i] & c);
      end
      // Skip mux: a fully propagating group forwards its incoming carry directly.
      c_nx[k] = (&p) ? cy_in[k] : c;
      s_nx[k] = (s_in[k] >> BLOCK) | (WIDTH'(sl) << (WIDTH - BLOCK));
      a_nx[k] = a_in[k] >> BLOCK;
      b_nx[k] = b_in[k] >> BLOCK;
      if (k == NB - 1) begin
        ovf_nx = c_top ^ c_nx[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NB; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NB; k++) begin
        a_q[k] <= a_nx[k];
        b_q[k] <= b_nx[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
        v_q[k] <= v_in[k];
      end
      ovf_q <= ovf_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z_cska_pipe.sv
// tb_z_cska_pipe: directed and random checks of z_cska_pipe (WIDTH=16, BLOCK=4) using a result scoreboard.
`default_nettype none

module tb_z_cska_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        c_out;
  logic        overflow;

  int nvec = 0;
  int nerr = 0;
  logic [17:0] sb [$];

  z_cska_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {sum, c_out, overflow}. Overflow from operand/result sign bits.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] be;
    logic [16:0] t;
    logic        ov;
    be = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, be} + 17'(s ? 1'b1 : ci);
    ov = (x[15] == be[15]) && (t[15] != x[15]);
    return {t[15:0], t[16], ov};
  endfunction

  // Consumer side: a result is taken on the edge following a negedge with out_valid & out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("result", 32'({sum, c_out, overflow}), 32'(sb.pop_front()));
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic ts, input logic [17:0] exp);
    int n;
    n = 0;
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    sb.push_back(exp);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_all_delivered", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] snap;
    logic [15:0] ra, rb;
    logic        rc, rs;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with exact latency and one-cycle valid pulse
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0});
    chk("lat_valid_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_c2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_c3", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_c4", 32'(out_valid), 32'd1);
    chk("lat_sum", 32'(sum), 32'h5555);
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(out_valid), 32'd0);
    drain();

    // Skip chain, signed overflow, subtraction
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    send(16'hF0F0, 16'h0F0F, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});
    drain();

    // Back-to-back random stream
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    drain();

    // Backpressure: 4 sent, stall 3 cycles with a 5th presented, then finish the stream
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      send(ra, rb, 1'b0, rs, model(ra, rb, 1'b0, rs));
    end
    out_ready = 1'b0;
    ra = 16'($urandom); rb = 16'($urandom);
    a = ra; b = rb; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    snap = sum;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum_stable", 32'(sum), 32'(snap));
    end
    out_ready = 1'b1;
    send(ra, rb, 1'b1, 1'b0, model(ra, rb, 1'b1, 1'b0));
    ra = 16'($urandom); rb = 16'($urandom);
    send(ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b1));
    drain();

    // Reset mid-flight with results backed up behind a stalled output
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, {16'h3333, 1'b0, 1'b0});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    send(16'h0100, 16'h0001, 1'b0, 1'b1, {16'h00FF, 1'b1, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_after_rst", 32'(out_valid), 32'd0);
    end
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sum", 32'(sum), 32'h0100);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
